pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage.sv | 131 +++++++++++++
 tb/tb_pipe_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register carrying a PC + instruction pair with flush.
// Define PIPE_STAGE_SKID_EN for the two-entry build with a registered in_ready.
module pipe_stage #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occ
);

    logic               main_valid_q, main_valid_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_xfer = main_valid_q && out_ready;

    // Data fields are masked when empty so stale payloads never leak out.
    assign out_valid = main_valid_q;
    assign out_pc    = main_valid_q ? main_pc_q : '0;
    assign out_instr = main_valid_q ? main_instr_q : NOP_INSTR;

`ifdef PIPE_STAGE_SKID_EN
    logic               skid_valid_q, skid_valid_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               in_ready_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_xfer) begin
            // in_ready is low whenever the skid is full, so no arrival can collide here
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_pc_d    = skid_pc_q;
                main_instr_d = skid_instr_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_xfer;
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end
        end else if (in_xfer) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        main_pc_q    <= main_pc_d;
        main_instr_q <= main_instr_d;
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

    assign in_ready = in_ready_q;
    assign occ      = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        main_pc_q    <= main_pc_d;
        main_instr_q <= main_instr_d;
    end

    assign in_ready = !main_valid_q || out_ready;
    assign occ      = {1'b0, main_valid_q};
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: vector table, directed stall/flush/reset
// sequences and a random run against a queue-based reference.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [1:0]  occ;

    logic        w_in_valid, w_out_ready, w_flush;
    logic [15:0] w_in_pc, w_out_pc;
    logic [63:0] w_in_instr, w_out_instr;
    logic        w_in_ready, w_out_valid;
    logic [1:0]  w_occ;

    always #5 clk = ~clk;

    pipe_stage u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .occ(occ)
    );

    pipe_stage #(.PC_W(16), .INSTR_W(64), .NOP_INSTR(64'h13)) u_wide (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_pc(w_in_pc), .in_instr(w_in_instr),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr),
        .occ(w_occ)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;
    beat_t sb_q[$];

    typedef struct {
        bit          in_valid;
        logic [31:0] pc;
        logic [31:0] instr;
        bit          out_ready;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [1:0]  exp_occ;
    } vec_t;
    vec_t vecs[6];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit exp_in_ready();
        if (SKID) return sb_q.size() < 2;
        return (sb_q.size() == 0) || out_ready;
    endfunction

    task automatic drive(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                         input logic [31:0] ins, input bit ordy);
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    endtask

    // Compare every DUT output with the reference queue; call at the falling edge.
    task automatic check_model();
        chk("in_ready", in_ready, exp_in_ready());
        chk("occ", occ, sb_q.size());
        chk("out_valid", out_valid, sb_q.size() > 0);
        if (sb_q.size() > 0) begin
            chk("out_pc", out_pc, sb_q[0].pc);
            chk("out_instr", out_instr, sb_q[0].instr);
        end else begin
            chk("idle_pc", out_pc, 32'h0);
            chk("idle_instr", out_instr, 32'h0);
        end
    endtask

    task automatic tick();
        bit acc, ox;
        acc = in_valid && exp_in_ready() && !flush && !rst;
        ox  = (sb_q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            $display("clear (%s) dropping %0d beats", rst ? "rst" : "flush", sb_q.size());
            sb_q.delete();
        end else begin
            if (ox) begin
                $display("beat out pc=%h instr=%h", sb_q[0].pc, sb_q[0].instr);
                void'(sb_q.pop_front());
            end
            if (acc) sb_q.push_back('{pc: in_pc, instr: in_instr});
        end
        #1;
    endtask

    task automatic cyc(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit ordy);
        drive(r, f, iv, pc, ins, ordy);
        @(negedge clk);
        check_model();
        tick();
    endtask

    initial begin
        logic [31:0] next_pc;
        vecs[0] = '{1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,   32'h0, 2'd0};
        vecs[1] = '{1'b1, 32'h100, 32'hA, 1'b1, 1'b0, 32'h0,   32'h0, 2'd0};
        vecs[2] = '{1'b1, 32'h104, 32'hB, 1'b1, 1'b1, 32'h100, 32'hA, 2'd1};
        vecs[3] = '{1'b1, 32'h108, 32'hC, 1'b1, 1'b1, 32'h104, 32'hB, 2'd1};
        vecs[4] = '{1'b0, 32'h0,   32'h0, 1'b1, 1'b1, 32'h108, 32'hC, 2'd1};
        vecs[5] = '{1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0,   32'h0, 2'd0};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_pc = '0; w_in_instr = '0; w_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Wide parameterisation: reset bubble value and full-width passthrough.
        @(negedge clk);
        chk("wide_rst_instr", w_out_instr, 64'h13);
        chk("wide_rst_pc", w_out_pc, 64'h0);
        chk("wide_rst_valid", w_out_valid, 1'b0);
        w_in_valid = 1'b1; w_in_pc = 16'hBEEF; w_in_instr = 64'hDEAD_BEEF_0123_4567;
        @(posedge clk); #1 w_in_valid = 1'b0;
        @(negedge clk);
        chk("wide_valid", w_out_valid, 1'b1);
        chk("wide_pc", w_out_pc, 64'hBEEF);
        chk("wide_instr", w_out_instr, 64'hDEAD_BEEF_0123_4567);
        $display("wide beat out pc=%h instr=%h", w_out_pc, w_out_instr);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wide_empty_instr", w_out_instr, 64'h13);
        @(posedge clk); #1;

        // Streaming vectors: outputs expected before each edge.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, vecs[i].in_valid, vecs[i].pc, vecs[i].instr, vecs[i].out_ready);
            @(negedge clk);
            check_model();
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_occ", i), occ, vecs[i].exp_occ);
            tick();
        end

        // Downstream stall with a second beat offered.
        cyc(1'b0, 1'b0, 1'b1, 32'h100, 32'hA, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 32'h104, 32'hB, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h104, 32'hB, 1'b0);
        @(negedge clk);
        check_model();
        chk("stall_pc", out_pc, 32'h100);
        chk("stall_occ", occ, SKID ? 2'd2 : 2'd1);
        chk("stall_in_ready", in_ready, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h104, 32'hB, 1'b1);
        @(negedge clk);
        check_model();
        chk("release_first", out_pc, 32'h100);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_model();
        chk("release_second", out_pc, 32'h104);
        tick();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Flush beats a same-cycle input transfer.
        cyc(1'b0, 1'b0, 1'b1, 32'h200, 32'h20, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h204, 32'h24, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_model();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_occ", occ, 2'd0);
        chk("flush_instr", out_instr, 32'h0);
        tick();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset mid-stream with the stage full.
        cyc(1'b0, 1'b0, 1'b1, 32'h2F0, 32'h30, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h2F4, 32'h34, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h2F8, 32'h38, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h300, 32'h40, 1'b1);
        @(negedge clk);
        check_model();
        chk("rst_occ", occ, 2'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_model();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_pc", out_pc, 32'h300);
        tick();

        // Random traffic with occasional flushes.
        next_pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            cyc(1'b0, ($urandom % 64) == 0, $urandom_range(1, 0) == 1, next_pc, $urandom,
                ($urandom % 4) != 0);
            next_pc += 32'd4;
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
